// File: rtl/maple_frame_encoder.sv
`default_nettype none
// ============================================================================
// Module   : maple_frame_encoder
// Purpose  : Serialises an AXI-Stream byte stream onto the two-wire Maple bus
//            (SDCKA/SDCKB). A frame is a start pattern, then every byte MSB
//            first with alternating phase-1/phase-2 bit cells, then an end
//            pattern. A stalled stream aborts the frame after a bounded wait.
// Ports    : clk, reset           - rising-edge clock, synchronous active-high reset
//            enable               - frame start request (sampled in IDLE only)
//            S_AXIS_TVALID/TREADY/TLAST/TDATA - byte stream (ready only in FETCH)
//            sdcka, sdckb, sdc_oe - registered bus lines and drive enable
//            busy, done, underrun - registered status
// Revision : 1.0 - initial release
// ============================================================================
module maple_frame_encoder #(
  parameter int PHASE_CYCLES    = 2,
  parameter int START_PULSES    = 4,
  parameter int UNDERRUN_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       S_AXIS_TVALID,
  output logic       S_AXIS_TREADY,
  input  logic       S_AXIS_TLAST,
  input  logic [7:0] S_AXIS_TDATA,
  output logic       sdcka,
  output logic       sdckb,
  output logic       sdc_oe,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_START    = 4'd1,
    ST_FETCH    = 4'd2,
    ST_P1_SETUP = 4'd3,
    ST_P1_DATA  = 4'd4,
    ST_P1_HOLD  = 4'd5,
    ST_P2_SETUP = 4'd6,
    ST_P2_DATA  = 4'd7,
    ST_P2_HOLD  = 4'd8,
    ST_END      = 4'd9,
    ST_DONE     = 4'd10
  } state_t;

  // Down-counter reload value: a sub-phase ends when the counter reads zero.
  localparam logic [7:0]  PHASE_LOAD    = 8'(PHASE_CYCLES - 1);
  // Index of the final (1,1) sub-phase of the start pattern.
  localparam logic [5:0]  START_LAST    = 6'(1 + 2 * START_PULSES);
  localparam logic [5:0]  END_LAST      = 6'd2;
  localparam logic [15:0] UNDERRUN_LAST = 16'(UNDERRUN_CYCLES - 1);

  state_t      state, state_nx;
  logic [7:0]  phase_cnt, phase_nx;
  logic [5:0]  sub_idx, sub_nx;
  logic [2:0]  bit_cnt, bit_nx;
  logic [15:0] fetch_cnt, fetch_nx;
  logic [7:0]  shift_reg, shift_nx;
  logic        last_latch, last_nx;
  logic        a_nx, b_nx, under_nx;
  logic        sub_end;

  assign sub_end       = (phase_cnt == 8'd0);
  assign S_AXIS_TREADY = (state == ST_FETCH);

  // Next-state, counter and line decode. Lines are computed from the next
  // state so the registered outputs change on the same edge as the state.
  always_comb begin
    state_nx = state;
    phase_nx = sub_end ? PHASE_LOAD : (phase_cnt - 8'd1);
    sub_nx   = sub_idx;
    bit_nx   = bit_cnt;
    fetch_nx = fetch_cnt;
    shift_nx = shift_reg;
    last_nx  = last_latch;
    under_nx = 1'b0;
    a_nx     = sdcka;
    b_nx     = sdckb;

    case (state)
      ST_IDLE: begin
        phase_nx = phase_cnt;
        if (enable) begin
          state_nx = ST_START;
          phase_nx = PHASE_LOAD;
          sub_nx   = 6'd0;
        end
      end
      ST_START: begin
        if (sub_end) begin
          if (sub_idx == START_LAST) begin
            state_nx = ST_FETCH;
            fetch_nx = 16'd0;
          end else begin
            sub_nx = sub_idx + 6'd1;
          end
        end
      end
      ST_FETCH: begin
        phase_nx = PHASE_LOAD;
        if (S_AXIS_TVALID) begin
          state_nx = ST_P1_SETUP;
          shift_nx = S_AXIS_TDATA;
          last_nx  = S_AXIS_TLAST;
          bit_nx   = 3'd0;
        end else if (fetch_cnt == UNDERRUN_LAST) begin
          // Abort: the partially sent frame is closed with the END pattern.
          state_nx = ST_END;
          sub_nx   = 6'd0;
          under_nx = 1'b1;
        end else begin
          fetch_nx = fetch_cnt + 16'd1;
        end
      end
      ST_P1_SETUP: if (sub_end) state_nx = ST_P1_DATA;
      ST_P1_DATA:  if (sub_end) state_nx = ST_P1_HOLD;
      ST_P1_HOLD: begin
        if (sub_end) begin
          state_nx = ST_P2_SETUP;
          bit_nx   = bit_cnt + 3'd1;
          shift_nx = {shift_reg[6:0], 1'b0};
        end
      end
      ST_P2_SETUP: if (sub_end) state_nx = ST_P2_DATA;
      ST_P2_DATA:  if (sub_end) state_nx = ST_P2_HOLD;
      ST_P2_HOLD: begin
        if (sub_end) begin
          bit_nx   = bit_cnt + 3'd1;
          shift_nx = {shift_reg[6:0], 1'b0};
          if (bit_cnt == 3'd7) begin
            if (last_latch) begin
              state_nx = ST_END;
              sub_nx   = 6'd0;
            end else begin
              state_nx = ST_FETCH;
              fetch_nx = 16'd0;
            end
          end else begin
            state_nx = ST_P1_SETUP;
          end
        end
      end
      ST_END: begin
        if (sub_end) begin
          if (sub_idx == END_LAST) state_nx = ST_DONE;
          else                     sub_nx   = sub_idx + 6'd1;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase

    case (state_nx)
      ST_IDLE, ST_DONE: begin
        a_nx = 1'b1;
        b_nx = 1'b1;
      end
      ST_START: begin
        // (0,1), then pulse pairs (0,0)/(0,1), closing with (1,1).
        a_nx = (sub_nx == START_LAST);
        b_nx = (sub_nx == START_LAST) || !sub_nx[0];
      end
      ST_P1_SETUP: a_nx = 1'b1;
      ST_P1_DATA: begin
        a_nx = 1'b1;
        b_nx = shift_nx[7];
      end
      ST_P1_HOLD:  a_nx = 1'b0;
      ST_P2_SETUP: b_nx = 1'b1;
      ST_P2_DATA: begin
        b_nx = 1'b1;
        a_nx = shift_nx[7];
      end
      ST_P2_HOLD:  b_nx = 1'b0;
      ST_END: begin
        a_nx = (sub_nx != 6'd1);
        b_nx = 1'b0;
      end
      default: ;  // FETCH keeps the lines where the last cell left them
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      phase_cnt  <= 8'd0;
      sub_idx    <= 6'd0;
      bit_cnt    <= 3'd0;
      fetch_cnt  <= 16'd0;
      shift_reg  <= 8'd0;
      last_latch <= 1'b0;
      sdcka      <= 1'b1;
      sdckb      <= 1'b1;
      sdc_oe     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_nx;
      phase_cnt  <= phase_nx;
      sub_idx    <= sub_nx;
      bit_cnt    <= bit_nx;
      fetch_cnt  <= fetch_nx;
      shift_reg  <= shift_nx;
      last_latch <= last_nx;
      sdcka      <= a_nx;
      sdckb      <= b_nx;
      sdc_oe     <= (state_nx != ST_IDLE) && (state_nx != ST_DONE);
      busy       <= (state_nx != ST_IDLE);
      done       <= (state_nx == ST_DONE);
      underrun   <= under_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_maple_frame_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_maple_frame_encoder
// Purpose  : Self-checking bench for maple_frame_encoder. A waveform model
//            expands each frame (bytes, stalls, abort) into the expected
//            per-cycle line/status values and the stimulus to apply, and the
//            DUT is compared against it every cycle. Two instances are used:
//            PHASE_CYCLES=2 and PHASE_CYCLES=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_maple_frame_encoder;

  localparam int SP = 4;
  localparam int UR = 16;

  logic       clk = 1'b0;
  logic       reset, enable, tvalid, tlast;
  logic [7:0] tdata;
  logic p2_ready, p2_a, p2_b, p2_oe, p2_busy, p2_done, p2_und;
  logic p1_ready, p1_a, p1_b, p1_oe, p1_busy, p1_done, p1_und;

  always #5 clk = ~clk;

  maple_frame_encoder #(.PHASE_CYCLES(2), .START_PULSES(SP), .UNDERRUN_CYCLES(UR)) dut_p2 (
    .clk(clk), .reset(reset), .enable(enable),
    .S_AXIS_TVALID(tvalid), .S_AXIS_TREADY(p2_ready), .S_AXIS_TLAST(tlast), .S_AXIS_TDATA(tdata),
    .sdcka(p2_a), .sdckb(p2_b), .sdc_oe(p2_oe), .busy(p2_busy), .done(p2_done), .underrun(p2_und)
  );

  maple_frame_encoder #(.PHASE_CYCLES(1), .START_PULSES(SP), .UNDERRUN_CYCLES(UR)) dut_p1 (
    .clk(clk), .reset(reset), .enable(enable),
    .S_AXIS_TVALID(tvalid), .S_AXIS_TREADY(p1_ready), .S_AXIS_TLAST(tlast), .S_AXIS_TDATA(tdata),
    .sdcka(p1_a), .sdckb(p1_b), .sdc_oe(p1_oe), .busy(p1_busy), .done(p1_done), .underrun(p1_und)
  );

  // Observed/expected vector layout: {A, B, oe, busy, done, underrun, ready}
  typedef struct {
    logic [6:0] exp;
    logic       en;
    logic       valid;
    logic [7:0] data;
    logic       last;
  } cyc_t;

  cyc_t       sched[$];
  int         pos, ph, en_mode, nb, mark_b3;
  bit         sel1, do_under, pend_under;
  logic       cur_a, cur_b;
  logic [7:0] fb [8];
  int         fw [8];
  int         n_assert, n_fail;
  int         hs, busy_cnt, done_cnt, und_cnt, both_low, edges_a, edges_b;
  bit         have_prev;
  logic       prev_a, prev_b;
  string      test_name;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] cur_obs();
    if (sel1) return {p1_a, p1_b, p1_oe, p1_busy, p1_done, p1_und, p1_ready};
    return {p2_a, p2_b, p2_oe, p2_busy, p2_done, p2_und, p2_ready};
  endfunction

  function automatic logic en_val();
    if (en_mode == 2) return 1'($urandom_range(0, 1));
    return (en_mode == 1);
  endfunction

  // ---------------- reference waveform model ----------------
  task automatic push(input logic [6:0] e, input logic en, input logic valid,
                      input logic [7:0] data, input logic last);
    cyc_t c;
    c.exp = e; c.en = en; c.valid = valid; c.data = data; c.last = last;
    sched.push_back(c);
  endtask

  // One timed sub-phase of ph cycles with the bus driven to (a,b).
  task automatic push_sub(input logic a, input logic b);
    for (int i = 0; i < ph; i++) begin
      push({a, b, 1'b1, 1'b1, 1'b0, pend_under, 1'b0}, en_val(), 1'b0, 8'h00, 1'b0);
      pend_under = 1'b0;
    end
    cur_a = a;
    cur_b = b;
  endtask

  task automatic push_fetch(input logic valid, input logic [7:0] data, input logic last);
    push({cur_a, cur_b, 5'b11001}, en_val(), valid, data, last);
  endtask

  task automatic push_idle();
    push(7'b1100000, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic build_frame();
    logic bitv;
    push(7'b1100000, 1'b1, 1'b0, 8'h00, 1'b0);  // IDLE cycle where enable is taken
    cur_a = 1'b1;
    cur_b = 1'b1;
    push_sub(1'b0, 1'b1);
    for (int p = 0; p < SP; p++) begin
      push_sub(1'b0, 1'b0);
      push_sub(1'b0, 1'b1);
    end
    push_sub(1'b1, 1'b1);
    for (int j = 0; j < nb; j++) begin
      for (int w = 0; w < fw[j]; w++) push_fetch(1'b0, 8'h00, 1'b0);
      push_fetch(1'b1, fb[j], !do_under && (j == nb - 1));
      for (int i = 0; i < 8; i++) begin
        bitv = fb[j][7-i];
        if (i % 2 == 0) begin
          push_sub(1'b1, cur_b);
          push_sub(1'b1, bitv);
          push_sub(1'b0, bitv);
        end else begin
          push_sub(cur_a, 1'b1);
          if (j == 0 && i == 3) mark_b3 = sched.size();
          push_sub(bitv, 1'b1);
          push_sub(bitv, 1'b0);
        end
      end
    end
    if (do_under) begin
      for (int w = 0; w < UR; w++) push_fetch(1'b0, 8'h00, 1'b0);
      pend_under = 1'b1;
    end
    push_sub(1'b1, 1'b0);
    push_sub(1'b0, 1'b0);
    push_sub(1'b1, 1'b0);
    push(7'b1101100, en_val(), 1'b0, 8'h00, 1'b0);  // DONE
  endtask

  // ---------------- driver / comparator ----------------
  task automatic clear_stats();
    hs = 0; busy_cnt = 0; done_cnt = 0; und_cnt = 0;
    both_low = 0; edges_a = 0; edges_b = 0; have_prev = 1'b0;
  endtask

  task automatic new_sched();
    sched.delete();
    pos = 0;
  endtask

  task automatic record(input logic [6:0] obs);
    if (obs[0] && tvalid) hs++;
    if (obs[3]) busy_cnt++;
    if (obs[2]) done_cnt++;
    if (obs[1]) und_cnt++;
    if (!obs[6] && !obs[5]) both_low++;
    if (have_prev) begin
      if (obs[6] !== prev_a) edges_a++;
      if (obs[5] !== prev_b) edges_b++;
    end
    prev_a = obs[6];
    prev_b = obs[5];
    have_prev = 1'b1;
  endtask

  task automatic run_to(input int upto);
    cyc_t c;
    logic [6:0] obs;
    while (pos < upto) begin
      c = sched[pos];
      enable = c.en;
      if (!c.exp[0]) begin
        // Stream inputs are don't-care outside FETCH: drive noise.
        tvalid = 1'($urandom_range(0, 1));
        tdata  = 8'($urandom);
        tlast  = 1'($urandom_range(0, 1));
      end else begin
        tvalid = c.valid;
        tdata  = c.valid ? c.data : 8'($urandom);
        tlast  = c.valid ? c.last : 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      obs = cur_obs();
      record(obs);
      check($sformatf("%s cycle %0d", test_name, pos), {25'd0, obs}, {25'd0, c.exp});
      @(posedge clk);
      #1;
      pos++;
    end
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic random_frame();
    nb = $urandom_range(1, 4);
    for (int j = 0; j < nb; j++) begin
      fb[j] = 8'($urandom);
      fw[j] = $urandom_range(0, 5);
    end
    do_under = ($urandom_range(0, 3) == 0);
    en_mode  = 2;
    clear_stats();
    new_sched();
    build_frame();
    push_idle();
    run_to(sched.size());
    check({test_name, " handshakes"}, hs, nb);
    check({test_name, " done"}, done_cnt, 1);
    check({test_name, " underrun"}, und_cnt, do_under ? 1 : 0);
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    reset = 1'b1; enable = 1'b0; tvalid = 1'b0; tlast = 1'b0; tdata = 8'h00;
    sel1 = 1'b0; ph = 2; en_mode = 0; pend_under = 1'b0; do_under = 1'b0;
    pos = 0; mark_b3 = 0;
    clear_stats();

    // Reset state of both instances
    repeat (3) @(posedge clk);
    tvalid = 1'b1; enable = 1'b1; tdata = 8'h5A;
    @(negedge clk);
    check("reset_p2", {25'd0, p2_a, p2_b, p2_oe, p2_busy, p2_done, p2_und, p2_ready}, 32'h60);
    check("reset_p1", {25'd0, p1_a, p1_b, p1_oe, p1_busy, p1_done, p1_und, p1_ready}, 32'h60);
    @(posedge clk);
    #1;
    reset = 1'b0; enable = 1'b0; tvalid = 1'b0;

    // Single byte 0xA5, TLAST, TVALID already high, enable pulsed
    test_name = "a5_frame";
    nb = 1; fb[0] = 8'hA5; fw[0] = 0; do_under = 1'b0; en_mode = 0;
    clear_stats(); new_sched();
    build_frame(); push_idle();
    run_to(sched.size());
    check("a5_busy_cycles", busy_cnt, 76);
    check("a5_done_cycles", done_cnt, 1);
    check("a5_handshakes", hs, 1);

    // Three bytes 0x00, 0xFF, 0x3C with stalls
    test_name = "three_bytes";
    nb = 3; fb[0] = 8'h00; fb[1] = 8'hFF; fb[2] = 8'h3C;
    for (int j = 0; j < 3; j++) fw[j] = $urandom_range(0, 4);
    do_under = 1'b0; en_mode = 2;
    clear_stats(); new_sched();
    build_frame(); push_idle();
    run_to(sched.size());
    check("three_handshakes", hs, 3);
    check("three_done", done_cnt, 1);
    check("three_underrun", und_cnt, 0);

    // Second byte withheld -> underrun abort
    test_name = "underrun";
    nb = 1; fb[0] = 8'($urandom); fw[0] = $urandom_range(0, 3);
    do_under = 1'b1; en_mode = 2;
    clear_stats(); new_sched();
    build_frame(); push_idle();
    run_to(sched.size());
    check("underrun_pulses", und_cnt, 1);
    check("underrun_handshakes", hs, 1);
    check("underrun_done", done_cnt, 1);

    // Enable held high: back-to-back frames, no mid-frame restart
    test_name = "enable_held";
    do_under = 1'b0; en_mode = 1;
    clear_stats(); new_sched();
    nb = 2; fb[0] = 8'($urandom); fb[1] = 8'($urandom); fw[0] = 0; fw[1] = 2;
    build_frame();
    nb = 1; fb[0] = 8'($urandom); fw[0] = 1;
    build_frame();
    push_idle();
    run_to(sched.size());
    check("held_done", done_cnt, 2);
    check("held_handshakes", hs, 3);

    // Reset during P2_DATA of bit 3
    test_name = "midframe";
    nb = 2; fb[0] = 8'($urandom); fb[1] = 8'($urandom); fw[0] = 0; fw[1] = 0;
    do_under = 1'b0; en_mode = 2;
    clear_stats(); new_sched();
    build_frame();
    run_to(mark_b3 + 1);
    reset = 1'b1; enable = 1'b1; tvalid = 1'b1; tdata = 8'($urandom);
    @(posedge clk);
    #1;
    reset = 1'b0; enable = 1'b0; tvalid = 1'b0;
    @(negedge clk);
    check("midframe_reset_outputs", {25'd0, cur_obs()}, 32'h60);
    check("midframe_handshakes", hs, 1);
    @(posedge clk);
    #1;
    test_name = "after_reset";
    nb = 1; fb[0] = 8'($urandom); fw[0] = 0; en_mode = 0;
    clear_stats(); new_sched();
    build_frame(); push_idle();
    run_to(sched.size());
    check("after_reset_busy", busy_cnt, 76);
    check("after_reset_done", done_cnt, 1);

    // Randomized frames, PHASE_CYCLES=2
    for (int k = 0; k < 3; k++) begin
      test_name = $sformatf("rand_p2_%0d", k);
      random_frame();
    end

    // PHASE_CYCLES=1 instance
    reset_pulse();
    sel1 = 1'b1; ph = 1;
    test_name = "p1_ff";
    nb = 1; fb[0] = 8'hFF; fw[0] = 0; do_under = 1'b0; en_mode = 0;
    clear_stats(); new_sched();
    build_frame(); push_idle();
    run_to(sched.size());
    // Both lines low only in the 4 start pulses and the middle END sub-phase.
    check("p1_both_low", both_low, 5);
    check("p1_edges_a", edges_a, 12);
    check("p1_edges_b", edges_b, 16);
    check("p1_busy", busy_cnt, 39);
    for (int k = 0; k < 2; k++) begin
      test_name = $sformatf("rand_p1_%0d", k);
      random_frame();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
